// File: rtl/wb_trace_fifo_pkg.sv
// Shared types and constants for the write-back trace FIFO.
// An entry is the retiring PC in the upper half and the register write data in the lower half.
package wb_trace_fifo_pkg;

   localparam int TRACE_W   = 64;
   localparam int PC_MSB    = 63;
   localparam int PC_LSB    = 32;
   localparam int WD_MSB    = 31;
   localparam int WD_LSB    = 0;
   localparam int DEF_DEPTH = 8;
   localparam int DEF_DCW   = 16;

   typedef logic [TRACE_W-1:0] trace_t;

   function automatic trace_t pack_trace(input logic [31:0] pc, input logic [31:0] wd);
      return {pc, wd};
   endfunction

endpackage

// File: rtl/wb_trace_fifo_if.sv
// Valid/ready stream carrying captured trace entries from the FIFO head to a consumer.
interface wb_trace_fifo_if;
   import wb_trace_fifo_pkg::*;

   logic                       o_vld;
   logic [PC_MSB-PC_LSB:0]     o_pc;
   logic [WD_MSB-WD_LSB:0]     o_wd;
   logic                       i_rdy;

   modport master (output o_vld, output o_pc, output o_wd, input i_rdy);
   modport slave  (input o_vld, input o_pc, input o_wd, output i_rdy);

endinterface

// File: rtl/wb_trace_mem.sv
// DEPTH x TRACE_W register array: synchronous write, asynchronous read, no reset.
module wb_trace_mem
   import wb_trace_fifo_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = 3
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  trace_t        i_wdata,
   input  logic [AW-1:0] i_raddr,
   output trace_t        o_rdata
);

   trace_t mem_q [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// First-word-fall-through trace FIFO for retired instructions; the core is never stalled,
// entries arriving while full are dropped and counted.
module wb_trace_fifo
   import wb_trace_fifo_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = 3,
   parameter int DCW   = DEF_DCW
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_en,
   input  logic [31:0]         i_pc,
   input  logic [31:0]         i_wd,
   input  logic                i_clr,
   wb_trace_fifo_if.master     trc,
   output logic [AW:0]         o_count,
   output logic                o_full,
   output logic                o_empty,
   output logic                o_ovf,
   output logic [DCW-1:0]      o_drop_cnt
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           ovf_q, ovf_d;
   logic [DCW-1:0] drop_cnt_q, drop_cnt_d;

   logic   empty, full, pop, push, drop, mem_we;
   trace_t head;

   // Status comes from the count register only, so no input reaches o_full/o_empty.
   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign pop   = !empty && trc.i_rdy;
   assign push  = i_en && (!full || pop);
   assign drop  = i_en && full && !pop;
   assign mem_we = push && !i_clr;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
      if (i_clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         ovf_d      = 1'b0;
         drop_cnt_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + (AW+1)'(1);
         else if (pop && !push) count_d = count_q - (AW+1)'(1);
         if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DCW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   wb_trace_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (mem_we),
      .i_waddr (wr_ptr_q),
      .i_wdata (pack_trace(i_pc, i_wd)),
      .i_raddr (rd_ptr_q),
      .o_rdata (head)
   );

   // Head is forced to zero while empty so stale storage never leaks out.
   assign trc.o_vld  = !empty;
   assign trc.o_pc   = empty ? '0 : head[PC_MSB:PC_LSB];
   assign trc.o_wd   = empty ? '0 : head[WD_MSB:WD_LSB];
   assign o_count    = count_q;
   assign o_full     = full;
   assign o_empty    = empty;
   assign o_ovf      = ovf_q;
   assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo: reset, pass-through, overflow, full push+pop, clear, async reset.
module tb_wb_trace_fifo;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_en;
   logic [31:0] i_pc;
   logic [31:0] i_wd;
   logic        i_clr;
   logic [3:0]  o_count;
   logic        o_full;
   logic        o_empty;
   logic        o_ovf;
   logic [15:0] o_drop_cnt;

   int checks;
   int errors;

   wb_trace_fifo_if trc ();

   wb_trace_fifo #(.DEPTH(8), .AW(3), .DCW(16)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (i_en),
      .i_pc       (i_pc),
      .i_wd       (i_wd),
      .i_clr      (i_clr),
      .trc        (trc.master),
      .o_count    (o_count),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_ovf      (o_ovf),
      .o_drop_cnt (o_drop_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_en = 1'b0; i_pc = '0; i_wd = '0; i_clr = 1'b0; trc.i_rdy = 1'b0;
      repeat (3) step();
      i_rst_n = 1'b1;
      step();
      checks++; if (trc.o_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", trc.o_vld); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", o_empty); end
      checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", o_full); end
      checks++; if (o_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
      checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
      checks++; if (o_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", o_drop_cnt); end
      checks++; if (trc.o_pc !== 32'h0 || trc.o_wd !== 32'h0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", trc.o_pc, trc.o_wd); end
   endtask

   task automatic test_single();
      i_en = 1'b1; i_pc = 32'h0000_0004; i_wd = 32'h0000_002A;
      #1;
      checks++; if (trc.o_vld !== 1'b0) begin errors++; $display("FAIL single_nobypass got %b want 0", trc.o_vld); end
      step();
      i_en = 1'b0;
      checks++; if (trc.o_vld !== 1'b1) begin errors++; $display("FAIL single_vld got %b want 1", trc.o_vld); end
      checks++; if (trc.o_pc !== 32'h4 || trc.o_wd !== 32'h2A) begin errors++; $display("FAIL single_data got %h/%h want 4/2a", trc.o_pc, trc.o_wd); end
      checks++; if (o_count !== 4'd1) begin errors++; $display("FAIL single_count got %0d want 1", o_count); end
      trc.i_rdy = 1'b1;
      step();
      trc.i_rdy = 1'b0;
      checks++; if (o_empty !== 1'b1 || trc.o_vld !== 1'b0) begin errors++; $display("FAIL single_pop got empty=%b vld=%b want 1/0", o_empty, trc.o_vld); end
      checks++; if (trc.o_pc !== 32'h0) begin errors++; $display("FAIL single_empty_pc got %h want 0", trc.o_pc); end
   endtask

   task automatic test_fill_overflow();
      for (int k = 0; k < 10; k++) begin
         i_en = 1'b1; i_pc = 32'(4 * k); i_wd = 32'(100 + k);
         step();
      end
      i_en = 1'b0;
      checks++; if (o_full !== 1'b1 || o_count !== 4'd8) begin errors++; $display("FAIL ovf_full got full=%b count=%0d want 1/8", o_full, o_count); end
      checks++; if (o_drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", o_drop_cnt); end
      checks++; if (o_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", o_ovf); end
      trc.i_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (trc.o_vld !== 1'b1 || trc.o_pc !== 32'(4 * k) || trc.o_wd !== 32'(100 + k)) begin
            errors++; $display("FAIL drain_%0d got vld=%b pc=%h wd=%h want 1/%h/%h", k, trc.o_vld, trc.o_pc, trc.o_wd, 32'(4 * k), 32'(100 + k));
         end
         step();
      end
      trc.i_rdy = 1'b0;
      checks++; if (trc.o_vld !== 1'b0 || o_count !== 4'd0) begin errors++; $display("FAIL drain_end got vld=%b count=%0d want 0/0", trc.o_vld, o_count); end
      checks++; if (o_ovf !== 1'b1 || o_drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_sticky got ovf=%b drop=%0d want 1/2", o_ovf, o_drop_cnt); end
   endtask

   task automatic test_full_push_pop();
      for (int k = 0; k < 8; k++) begin
         i_en = 1'b1; i_pc = 32'h1000 + 32'(4 * k); i_wd = 32'(k);
         step();
      end
      trc.i_rdy = 1'b1;
      for (int j = 0; j < 16; j++) begin
         i_en = 1'b1; i_pc = 32'h1000 + 32'(4 * (8 + j)); i_wd = 32'(8 + j);
         checks++;
         if (trc.o_pc !== 32'h1000 + 32'(4 * j) || trc.o_wd !== 32'(j) || o_count !== 4'd8) begin
            errors++; $display("FAIL pushpop_%0d got pc=%h wd=%h count=%0d want %h/%h/8", j, trc.o_pc, trc.o_wd, o_count, 32'h1000 + 32'(4 * j), 32'(j));
         end
         step();
      end
      i_en = 1'b0; trc.i_rdy = 1'b0;
      checks++; if (o_count !== 4'd8 || o_full !== 1'b1) begin errors++; $display("FAIL pushpop_count got %0d want 8", o_count); end
      checks++; if (o_drop_cnt !== 16'd2) begin errors++; $display("FAIL pushpop_drop got %0d want 2", o_drop_cnt); end
      checks++; if (trc.o_pc !== 32'h1040) begin errors++; $display("FAIL pushpop_head got %h want 1040", trc.o_pc); end
   endtask

   task automatic test_clear();
      i_clr = 1'b1; i_en = 1'b1; i_pc = 32'hDEAD_BEEF; i_wd = 32'hCAFE_F00D;
      step();
      i_clr = 1'b0; i_en = 1'b0;
      checks++; if (o_count !== 4'd0 || o_empty !== 1'b1) begin errors++; $display("FAIL clr_count got %0d want 0", o_count); end
      checks++; if (o_ovf !== 1'b0 || o_drop_cnt !== 16'd0) begin errors++; $display("FAIL clr_ovf got ovf=%b drop=%0d want 0/0", o_ovf, o_drop_cnt); end
      checks++; if (trc.o_vld !== 1'b0) begin errors++; $display("FAIL clr_vld got %b want 0", trc.o_vld); end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 5; k++) begin
         i_en = 1'b1; i_pc = 32'h2000 + 32'(4 * k); i_wd = 32'(k);
         step();
      end
      i_en = 1'b0;
      checks++; if (o_count !== 4'd5 || trc.o_pc !== 32'h2000) begin errors++; $display("FAIL areset_pre got count=%0d pc=%h want 5/2000", o_count, trc.o_pc); end
      #2;
      i_rst_n = 1'b0;
      #1;
      checks++; if (trc.o_vld !== 1'b0 || o_count !== 4'd0) begin errors++; $display("FAIL areset_vld got vld=%b count=%0d want 0/0", trc.o_vld, o_count); end
      step();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      trc.i_rdy = 1'b1;
      i_en = 1'b1; i_pc = 32'h3000; i_wd = 32'h77;
      step();
      i_en = 1'b0;
      checks++; if (trc.o_vld !== 1'b1 || trc.o_pc !== 32'h3000 || trc.o_wd !== 32'h77 || o_count !== 4'd1) begin
         errors++; $display("FAIL areset_head got vld=%b pc=%h wd=%h count=%0d want 1/3000/77/1", trc.o_vld, trc.o_pc, trc.o_wd, o_count);
      end
      step();
      trc.i_rdy = 1'b0;
      checks++; if (trc.o_vld !== 1'b0 || o_empty !== 1'b1) begin errors++; $display("FAIL areset_alone got vld=%b empty=%b want 0/1", trc.o_vld, o_empty); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_push_pop();
      test_clear();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Downstream debug stage for the single-cycle core.
- Captures each retired instruction's PC and register-file write data (the core's Out_PC / Out_RF_Write_Data) into a small first-word-fall-through FIFO.
- Presents the captured pairs on a valid/ready interface to a slower consumer (UART dumper, testbench monitor).
- When the FIFO is full, new entries are dropped and counted; the core is never stalled.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of 2, minimum 2.
- AW, 3, pointer width; equals log2(DEPTH).
- DCW, 16, width of the dropped-entry counter.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  capture strobe; 1 = push {i_pc, i_wd} this cycle.
- i_pc  input  32  PC of the retiring instruction (Out_PC).
- i_wd  input  32  register write data of the retiring instruction (Out_RF_Write_Data).
- i_clr  input  1  synchronous flush; also clears the overflow flag and drop counter.
- i_rdy  input  1  consumer ready.
- o_vld  output  1  head entry valid.
- o_pc  output  32  head entry PC.
- o_wd  output  32  head entry write data.
- o_count  output  AW+1  current occupancy, 0..DEPTH.
- o_full  output  1  o_count == DEPTH.
- o_empty  output  1  o_count == 0.
- o_ovf  output  1  sticky flag; set once at least one entry has been dropped.
- o_drop_cnt  output  DCW  number of dropped entries; saturates at all-ones.

Behaviour:
- Reset (asynchronous, i_rst_n = 0):
  - Write/read pointers, count, o_ovf and o_drop_cnt go to 0.
  - o_vld = 0, o_empty = 1, o_full = 0.
  - Storage array is not reset.
- Storage and pointers:
  - Entry = {pc[31:0], wd[31:0]}, 64 bits.
  - Pointers are AW bits wide and wrap naturally from DEPTH-1 to 0.
  - Count is tracked in a separate AW+1-bit register.
- Pop: pop = o_vld & i_rdy. The read pointer advances on that edge.
- Push acceptance: push is accepted when i_en & (!o_full | pop). Accepted data is written at the write pointer, which then advances.
- Count update: +1 on push only, -1 on pop only, unchanged on push+pop or when neither occurs.
- Output (FWFT):
  - o_vld = !o_empty.
  - o_pc/o_wd show the entry at the read pointer combinationally.
  - When empty, o_pc/o_wd are driven to 0, never stale data.
- Latency: an entry pushed into an empty FIFO appears on o_vld/o_pc/o_wd in the cycle after the push edge. It is never visible in the push cycle itself (no bypass).
- Full with i_en=1 and pop=1: push is accepted and count stays DEPTH. The freed slot is reused in the same edge. No drop occurs.
- Full with i_en=1 and pop=0:
  - The entry is dropped and nothing is written.
  - o_drop_cnt increments by 1, saturating at 2^DCW-1.
  - o_ovf is set to 1 and stays 1 until i_clr or reset.
- Empty with i_rdy=1 and no data: no pop; pointers are unchanged.
- i_clr=1: on the next edge, pointers, count, o_ovf and o_drop_cnt go to 0. i_clr has priority over any push, pop or drop in the same cycle; that cycle's push is discarded and not counted as dropped.
- Reset asserted mid-operation: all state clears immediately. Any pending entries are lost and o_vld drops asynchronously.
- o_full, o_empty and o_count are derived from the count register only, with no combinational path from i_en/i_rdy.

Decomposition:
- Shared package holds:
  - TRACE_W = 64 (entry width).
  - Field slice constants PC_MSB=63, PC_LSB=32, WD_MSB=31, WD_LSB=0.
  - Default DEPTH and DCW.
- One sub-module: wb_trace_mem, a DEPTH x 64 register array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset.
- wb_trace_fifo holds pointers, count, the drop/overflow logic and output gating.

Test Plan:
- Reset then idle: hold i_rst_n=0 for 3 cycles, release -> o_vld=0, o_empty=1, o_count=0, o_ovf=0, o_drop_cnt=0, o_pc=o_wd=0.
- Single pass: push {pc=32'h00000004, wd=32'h0000002A} with i_rdy=0 -> next cycle o_vld=1, o_pc=32'h4, o_wd=32'h2A, o_count=1. Assert i_rdy for 1 cycle -> o_empty=1.
- Fill and overflow: i_rdy=0, push 10 entries with pc=4*k -> o_full=1, o_count=8, o_drop_cnt=2, o_ovf=1. Then drain with i_rdy=1 -> pcs 0,4,...,28 in order, then o_vld=0.
- Full with simultaneous push+pop: with the FIFO full, i_en=1 and i_rdy=1 for 16 cycles -> o_count stays 8, o_drop_cnt unchanged, output order strictly FIFO across pointer wrap.
- Clear priority: full FIFO with o_ovf=1; assert i_clr with i_en=1 -> next cycle o_count=0, o_ovf=0, o_drop_cnt=0, o_vld=0.
- Async reset mid-stream: with 5 entries held, drop i_rst_n between clock edges -> o_vld=0 immediately. After release, the first new push appears alone at the head.
